// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg: shared state encoding and counter width for dac_batch_streamer.
`ifndef BATCH_WIDTH
`define BATCH_WIDTH 32
`endif
package dac_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, STREAM = 2'd2} dac_stream_state_t;
  localparam int DAC_STREAM_CNT_W = 16;
endpackage

// File: rtl/dac_batch_streamer_batch_ram.sv
// batch_ram: DEPTH x W simple dual-port memory, sync write, async read (distributed RAM).
module batch_ram #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/dac_batch_streamer.sv
// dac_batch_streamer: batch FIFO with prime/stream FSM feeding the RF DAC AXI-stream.
// DAC_BATCH_HOLD_EN: underflow filler repeats the last batch instead of zeros.
module dac_batch_streamer
  import dac_stream_pkg::*;
#(
  parameter int BATCH_W = `BATCH_WIDTH,
  parameter int DEPTH = 8,
  parameter int PRIME_LEVEL = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = AW + 1,
  localparam int CW = DAC_STREAM_CNT_W
) (
  input  logic               dac_clk,
  input  logic               dac_rstn,
  input  logic [BATCH_W-1:0] batch_in,
  input  logic               batch_in_valid,
  output logic               batch_in_rdy,
  input  logic               run,
  input  logic               flush,
  output logic [BATCH_W-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [FW-1:0]      fill_level,
  output logic [CW-1:0]      underflow_cnt,
  output logic [CW-1:0]      drop_cnt,
  output logic [1:0]         st
);
  dac_stream_state_t st_q, st_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [BATCH_W-1:0] tdata_q, tdata_d, head, filler;
  logic [CW-1:0] ucnt_q, ucnt_d, dcnt_q, dcnt_d;
  logic wr, pop, drop;
  assign batch_in_rdy = fill_q < FW'(DEPTH);
  assign wr = batch_in_valid && batch_in_rdy && !flush;
  assign drop = batch_in_valid && !batch_in_rdy;
`ifdef DAC_BATCH_HOLD_EN
  assign filler = tdata_q;
`else
  assign filler = '0;
`endif
  batch_ram #(.W(BATCH_W), .DEPTH(DEPTH)) u_ram (
    .clk_i(dac_clk), .we_i(wr), .waddr_i(wptr_q), .wdata_i(batch_in),
    .raddr_i(rptr_q), .rdata_o(head)
  );
  always_comb begin
    st_d = st_q;
    pop = 1'b0;
    tdata_d = tdata_q;
    ucnt_d = ucnt_q;
    dcnt_d = dcnt_q + CW'(drop && dcnt_q != '1);
    case (st_q)
      IDLE: st_d = run ? PRIME : IDLE;
      PRIME: begin
        pop = run && fill_q >= FW'(PRIME_LEVEL);
        tdata_d = pop ? head : tdata_q;
        st_d = !run ? IDLE : pop ? STREAM : PRIME;
      end
      STREAM: begin
        // a handshake in the run-drop cycle still completed, so the beat advances
        pop = m_tready && fill_q != '0;
        tdata_d = !m_tready ? tdata_q : pop ? head : filler;
        ucnt_d = ucnt_q + CW'(m_tready && !pop && ucnt_q != '1);
        st_d = run ? STREAM : IDLE;
      end
      default: st_d = IDLE;
    endcase
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    fill_d = fill_q + FW'(wr) - FW'(pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
      ucnt_d = '0;
      dcnt_d = '0;
      tdata_d = '0;
      st_d = (run && st_q != IDLE) ? PRIME : IDLE;
    end
  end
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      st_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      tdata_q <= '0;
      ucnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      st_q <= st_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      tdata_q <= tdata_d;
      ucnt_q <= ucnt_d;
      dcnt_q <= dcnt_d;
    end
  end
  assign m_tdata = tdata_q;
  assign m_tvalid = st_q == STREAM;
  assign fill_level = fill_q;
  assign underflow_cnt = ucnt_q;
  assign drop_cnt = dcnt_q;
  assign st = st_q;
endmodule

// File: tb/tb_dac_batch_streamer.sv
// tb_dac_batch_streamer: directed stimulus with a beat scoreboard on the AXI-stream side.
module tb_dac_batch_streamer;
  localparam int W = 32;
  logic clk = 0, dac_rstn = 0;
  logic [W-1:0] batch_in = '0, m_tdata;
  logic batch_in_valid = 0, batch_in_rdy, run = 0, flush = 0, m_tvalid, m_tready = 0;
  logic [3:0] fill_level;
  logic [15:0] underflow_cnt, drop_cnt;
  logic [1:0] st;
  int checks = 0, fails = 0;
  logic [W-1:0] exp_q [$];
  dac_batch_streamer #(.BATCH_W(W), .DEPTH(8), .PRIME_LEVEL(4)) dut (
    .dac_clk(clk), .dac_rstn(dac_rstn), .batch_in(batch_in), .batch_in_valid(batch_in_valid),
    .batch_in_rdy(batch_in_rdy), .run(run), .flush(flush), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .fill_level(fill_level), .underflow_cnt(underflow_cnt),
    .drop_cnt(drop_cnt), .st(st)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] fill_of(input logic [W-1:0] last);
`ifdef DAC_BATCH_HOLD_EN
    return last;
`else
    return '0;
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (dac_rstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL beat: unexpected m_tdata=%0h", m_tdata);
      end else chk("beat", m_tdata, exp_q.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) tick();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_rdy", batch_in_rdy, 1);
    chk("rst_fill", fill_level, 0);
    chk("rst_ucnt", underflow_cnt, 0);
    chk("rst_dcnt", drop_cnt, 0);
    chk("rst_st", st, 0);
    dac_rstn = 1;
    tick();
    run = 1;
    tick();
    chk("idle_to_prime", st, 1);
    m_tready = 1;
    for (int i = 1; i <= 4; i++) begin
      batch_in = W'(i);
      batch_in_valid = 1;
      exp_q.push_back(W'(i));
      tick();
    end
    batch_in_valid = 0;
    chk("prime_fill4", fill_level, 4);
    chk("prime_no_valid", m_tvalid, 0);
    tick();
    chk("stream_valid", m_tvalid, 1);
    chk("first_beat", m_tdata, 1);
    chk("fill_after_pop", fill_level, 3);
    repeat (3) tick();
    chk("last_beat", m_tdata, 4);
    chk("ucnt_before_empty", underflow_cnt, 0);
    chk("fill_empty", fill_level, 0);
    run = 0;
    tick();
    chk("run0_idle", st, 0);
    chk("run0_tvalid", m_tvalid, 0);
    chk("run0_ucnt", underflow_cnt, 1);
    chk("run0_filler", m_tdata, fill_of(4));
    flush = 1;
    tick();
    flush = 0;
    chk("flush_idle_st", st, 0);
    chk("flush_idle_ucnt", underflow_cnt, 0);
    chk("flush_idle_tdata", m_tdata, 0);
    m_tready = 0;
    for (int i = 0; i < 9; i++) begin
      batch_in = W'(32'hA4 + i);
      batch_in_valid = 1;
      if (i < 8) exp_q.push_back(W'(32'hA4 + i));
      else begin
        chk("full_rdy", batch_in_rdy, 0);
        chk("full_fill", fill_level, 8);
      end
      tick();
    end
    batch_in_valid = 0;
    chk("drop_cnt", drop_cnt, 1);
    chk("drop_fill", fill_level, 8);
    run = 1;
    tick();
    chk("prime_again", st, 1);
    tick();
    chk("stream_again", st, 2);
    repeat (5) tick();
    chk("stall_tdata", m_tdata, 32'hA4);
    chk("stall_fill", fill_level, 7);
    chk("stall_ucnt", underflow_cnt, 0);
    chk("stall_tvalid", m_tvalid, 1);
    m_tready = 1;
    repeat (7) tick();
    chk("ab_head", m_tdata, 32'hAB);
    chk("ab_fill", fill_level, 0);
    chk("ab_ucnt", underflow_cnt, 0);
    repeat (2) exp_q.push_back(fill_of(32'hAB));
    repeat (3) tick();
    m_tready = 0;
    chk("under_ucnt", underflow_cnt, 3);
    chk("under_tdata", m_tdata, fill_of(32'hAB));
    for (int i = 0; i < 5; i++) begin
      batch_in = W'(32'h50 + i);
      batch_in_valid = 1;
      tick();
    end
    batch_in_valid = 0;
    chk("pre_flush_fill", fill_level, 5);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_fill", fill_level, 0);
    chk("flush_ucnt", underflow_cnt, 0);
    chk("flush_dcnt", drop_cnt, 0);
    chk("flush_st", st, 1);
    chk("flush_tvalid", m_tvalid, 0);
    chk("flush_tdata", m_tdata, 0);
    m_tready = 1;
    for (int i = 0; i < 4; i++) begin
      batch_in = W'(32'h60 + i);
      batch_in_valid = 1;
      tick();
    end
    batch_in_valid = 0;
    exp_q.push_back(32'h60);
    tick();
    chk("pre_rst_tdata", m_tdata, 32'h60);
    tick();
    dac_rstn = 0;
    #1;
    chk("arst_tvalid", m_tvalid, 0);
    chk("arst_tdata", m_tdata, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_rdy", batch_in_rdy, 1);
    chk("arst_st", st, 0);
    run = 0;
    dac_rstn = 1;
    #1;
    chk("release_st", st, 0);
    tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dac_batch_streamer.md
# dac_batch_streamer

Elastic output stage between the PL sample generator's `dac_batch`/`valid_dac_batch` and the RF DAC AXI-stream slave. It buffers whole batches in a small FIFO and drives the upstream ready line (`dac0_rdy`) from FIFO occupancy. It primes before streaming, then presents a continuous AXI-stream to the DAC. Underflow and drop counts are exposed for the ILA and PS readback.

## Interface
- `BATCH_W`, default `` `BATCH_WIDTH ``: width of one DAC batch (all samples of one cycle, packed).
- `DEPTH`, default 8: FIFO depth in batches; power of two, ≥4.
- `PRIME_LEVEL`, default 4: occupancy required to leave PRIME; 1..DEPTH.
- `dac_clk`  in  1  sole clock.
- `dac_rstn`  in  1  reset; asynchronous assert, active-low.
- `batch_in`  in  BATCH_W  batch from the sample generator.
- `batch_in_valid`  in  1  batch_in qualifier.
- `batch_in_rdy`  out  1  FIFO not full; drives upstream `dac0_rdy`.
- `run`  in  1  level; 1 = stream to DAC.
- `flush`  in  1  single-cycle pulse; empties FIFO, clears counters.
- `m_tdata`  out  BATCH_W  batch to the DAC.
- `m_tvalid`  out  1  AXI-stream valid.
- `m_tready`  in  1  AXI-stream ready from the DAC.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `underflow_cnt`  out  16  saturating count of filler beats.
- `drop_cnt`  out  16  saturating count of batch_in_valid while !batch_in_rdy.
- `st`  out  2  state encoding, for ILA.

## Operation
- Reset values: m_tdata=0, m_tvalid=0, batch_in_rdy=1, fill_level=0, both counters=0, st=IDLE.
- Write: the FIFO accepts batch_in when batch_in_valid && batch_in_rdy. batch_in_rdy = (fill_level < DEPTH) and depends only on registered occupancy, never on a same-cycle pop. Writes are accepted in every state.
- Drop: batch_in_valid && !batch_in_rdy increments drop_cnt. Data is discarded.
- States:
  - IDLE (0): m_tvalid=0, no pops. Transitions to PRIME when run=1.
  - PRIME (1): m_tvalid=0. When fill_level ≥ PRIME_LEVEL, pop the head into m_tdata and go to STREAM.
  - STREAM (2): m_tvalid=1 continuously.
- Beat advance in STREAM: on every m_tvalid && m_tready, load the next head into m_tdata and pop it.
  - If the FIFO is empty, load the filler instead and increment underflow_cnt. The FIFO is not popped.
  - A write in the same cycle as an empty-pop is not bypassed: that beat is filler, and the written batch becomes the next head.
- run=0 in PRIME or STREAM: go to IDLE next cycle and deassert m_tvalid. FIFO contents are kept; m_tdata holds its value.
- flush: the next cycle has read/write pointers reset, fill_level=0, both counters=0, m_tdata=0. A write coincident with flush is discarded and not counted.
  - From STREAM or PRIME with run=1, go to PRIME; otherwise go to IDLE.
- Counters: 16-bit, saturate at 0xFFFF, no wrap.
- Pointers: $clog2(DEPTH) bits, natural wrap. Full and empty are derived from fill_level, not from pointer compare.
- Async reset mid-operation returns every register to its reset value immediately. The FIFO RAM contents are don't-care.

## Timing
- fill_level reflects an accepted write or pop one cycle later.
- Write-to-output latency: a write accepted at cycle n is the earliest PRIME exit candidate at n+1. It appears on m_tdata at n+2, with m_tvalid=1 from n+2.
- At full rate (m_tready=1 every cycle, input every cycle), throughput is one batch per cycle with no bubbles.
- m_tdata and m_tvalid are registered outputs with no combinational path from inputs. batch_in_rdy comes from a register and a compare only.
- Simultaneous write and pop at fill_level=DEPTH: the pop is accepted; batch_in_rdy was 0, so no write happens. fill_level becomes DEPTH-1 and batch_in_rdy=1 next cycle.

## Configuration
- `DAC_BATCH_HOLD_EN` defined: the underflow filler is the current m_tdata, so the last batch repeats and the DAC holds its level.
- `DAC_BATCH_HOLD_EN` undefined: the filler is all zeros (DAC mid-code).
- Counting and state behaviour are identical in both builds.

## Structure
- Shared package `dac_stream_pkg` holds:
  - the state enum `dac_stream_state_t` (IDLE=0, PRIME=1, STREAM=2);
  - the counter width constant `DAC_STREAM_CNT_W = 16`.
- One sub-module, `batch_ram`: simple dual-port DEPTH×BATCH_W memory with one synchronous write port and one asynchronous read port. It must infer distributed RAM.
- Counters, pointers and the FSM live in the top of the block.

## Test plan
- Reset, then run=1 and write 4 batches (0x1..0x4) with m_tready=1 → m_tvalid rises 2 cycles after the 4th write; m_tdata sequence is 0x1,0x2,0x3,0x4; underflow_cnt stays 0 until the FIFO empties.
- Write 9 batches back-to-back with run=0 → first 8 accepted; batch_in_rdy=0 on the 9th; drop_cnt=1; fill_level=8.
- STREAM with m_tready=1 and the FIFO empty for 3 cycles after last batch 0xAB → 3 filler beats, underflow_cnt=3; m_tdata=0xAB with HOLD_EN, 0 without.
- m_tready low for 5 cycles in STREAM → m_tdata stable, fill_level unchanged, underflow_cnt unchanged.
- flush pulse in STREAM with run=1 and fill_level=5 → next cycle fill_level=0, counters=0, st=PRIME, m_tvalid=0.
- dac_rstn asserted mid-STREAM → all outputs at reset values in the same cycle; after release, st=IDLE.
